// File: rtl/ps2_pkg.sv
// Shared PS/2 response codes, sequencer state and error encodings.
// The ASCII translator imports the same package for its break/extended prefixes.
package ps2_pkg;

  localparam int unsigned TIMER_W = 27;

  localparam logic [7:0] CODE_ACK       = 8'hFA;
  localparam logic [7:0] CODE_RESEND    = 8'hFE;
  localparam logic [7:0] CODE_ECHO      = 8'hEE;
  localparam logic [7:0] CODE_BAT_OK    = 8'hAA;
  localparam logic [7:0] CODE_BAT_FAIL  = 8'hFC;
  localparam logic [7:0] CODE_CMD_RESET = 8'hFF;
  localparam logic [7:0] CODE_BREAK     = 8'hF0;
  localparam logic [7:0] CODE_EXTENDED  = 8'hE0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TX_BYTE,
    S_WAIT_TX,
    S_WAIT_RESP,
    S_WAIT_BAT,
    S_FINISH,
    S_FAIL
  } seq_state_t;

  typedef enum logic [1:0] {
    ERR_NONE         = 2'b00,
    ERR_TIMEOUT      = 2'b01,
    ERR_RESEND_LIMIT = 2'b10,
    ERR_BAT_FAIL     = 2'b11
  } err_code_t;

endpackage

// File: rtl/ps2_timeout_counter.sv
// Loadable down-counter; expired_o rises once the count reaches zero and holds
// until the next load.
module ps2_timeout_counter
  import ps2_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load_i,
  input  logic [TIMER_W-1:0] value_i,
  output logic               expired_o
);

  logic [TIMER_W-1:0] count_q;
  logic               expired_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= '0;
      expired_q <= 1'b0;
    end else if (load_i) begin
      count_q   <= value_i;
      expired_q <= (value_i == '0);
    end else if (count_q != '0) begin
      count_q   <= count_q - TIMER_W'(1);
      expired_q <= (count_q == TIMER_W'(1));
    end
  end

  assign expired_o = expired_q;

endmodule

// File: rtl/ps2_cmd_sequencer.sv
// Host-to-keyboard command sequencer: sends opcode/argument, consumes the
// keyboard's ACK/RESEND/BAT replies, and forwards all other scan codes.
module ps2_cmd_sequencer
  import ps2_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT_CYCLES = 1_000_000,
  parameter int unsigned BAT_TIMEOUT_CYCLES = 100_000_000,
  parameter int unsigned MAX_RETRIES        = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  input  logic [7:0] req_cmd_i,
  input  logic       req_has_arg_i,
  input  logic [7:0] req_arg_i,
  output logic [7:0] tx_data_o,
  output logic       tx_start_o,
  input  logic       tx_done_i,
  input  logic       tx_error_i,
  input  logic [7:0] rx_code_i,
  input  logic       rx_valid_i,
  output logic [7:0] scan_code_o,
  output logic       scan_valid_o,
  output logic       cmd_done_o,
  output logic       cmd_err_o,
  output logic [1:0] err_code_o
);

  localparam int unsigned RETRY_W = $clog2(MAX_RETRIES + 1);

  seq_state_t         state_q;
  logic [7:0]         cmd_q;
  logic [7:0]         arg_q;
  logic               has_arg_q;
  logic               arg_phase_q;
  logic [7:0]         cur_byte_q;
  logic [RETRY_W-1:0] retries_q;
  logic               tmr_load_q;
  logic [TIMER_W-1:0] tmr_value_q;
  logic               req_ready_q;
  logic [7:0]         tx_data_q;
  logic               tx_start_q;
  logic [7:0]         scan_code_q;
  logic               scan_valid_q;
  logic               cmd_done_q;
  logic               cmd_err_q;
  err_code_t          err_code_q;

  logic       tmr_expired;
  logic       timed_out;
  logic       retry_ok;
  logic [7:0] expected_resp;
  logic       rx_consumed;

  ps2_timeout_counter u_timer (
    .clk       (clk),
    .reset     (reset),
    .load_i    (tmr_load_q),
    .value_i   (tmr_value_q),
    .expired_o (tmr_expired)
  );

  // The expiry flag is stale during the cycle the timer is being reloaded.
  assign timed_out     = tmr_expired && !tmr_load_q;
  assign retry_ok      = (retries_q < RETRY_W'(MAX_RETRIES));
  assign expected_resp = (cmd_q == CODE_ECHO) ? CODE_ECHO : CODE_ACK;

  always_comb begin
    rx_consumed = 1'b0;
    if (rx_valid_i) begin
      if (state_q == S_WAIT_RESP)
        rx_consumed = (rx_code_i == CODE_ACK) || (rx_code_i == CODE_RESEND) ||
                      (rx_code_i == expected_resp);
      else if (state_q == S_WAIT_BAT)
        rx_consumed = (rx_code_i == CODE_BAT_OK) || (rx_code_i == CODE_BAT_FAIL);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cmd_q        <= '0;
      arg_q        <= '0;
      has_arg_q    <= 1'b0;
      arg_phase_q  <= 1'b0;
      cur_byte_q   <= '0;
      retries_q    <= '0;
      tmr_load_q   <= 1'b0;
      tmr_value_q  <= '0;
      req_ready_q  <= 1'b1;
      tx_data_q    <= '0;
      tx_start_q   <= 1'b0;
      scan_code_q  <= '0;
      scan_valid_q <= 1'b0;
      cmd_done_q   <= 1'b0;
      cmd_err_q    <= 1'b0;
      err_code_q   <= ERR_NONE;
    end else begin
      tx_start_q   <= 1'b0;
      cmd_done_q   <= 1'b0;
      cmd_err_q    <= 1'b0;
      tmr_load_q   <= 1'b0;
      scan_valid_q <= rx_valid_i && !rx_consumed;
      if (rx_valid_i && !rx_consumed)
        scan_code_q <= rx_code_i;

      case (state_q)
        S_IDLE: begin
          if (req_valid_i) begin
            cmd_q       <= req_cmd_i;
            arg_q       <= req_arg_i;
            has_arg_q   <= req_has_arg_i;
            arg_phase_q <= 1'b0;
            cur_byte_q  <= req_cmd_i;
            retries_q   <= '0;
            err_code_q  <= ERR_NONE;
            req_ready_q <= 1'b0;
            state_q     <= S_TX_BYTE;
          end
        end
        S_TX_BYTE: begin
          tx_start_q <= 1'b1;
          tx_data_q  <= cur_byte_q;
          state_q    <= S_WAIT_TX;
        end
        S_WAIT_TX: begin
          if (tx_done_i) begin
            tmr_load_q  <= 1'b1;
            tmr_value_q <= TIMER_W'(ACK_TIMEOUT_CYCLES);
            state_q     <= S_WAIT_RESP;
          end else if (tx_error_i) begin
            if (retry_ok) begin
              retries_q <= retries_q + RETRY_W'(1);
              state_q   <= S_TX_BYTE;
            end else begin
              cmd_err_q  <= 1'b1;
              err_code_q <= ERR_RESEND_LIMIT;
              state_q    <= S_FAIL;
            end
          end
        end
        S_WAIT_RESP: begin
          if (rx_valid_i && rx_code_i == expected_resp) begin
            if (!arg_phase_q && has_arg_q) begin
              cur_byte_q  <= arg_q;
              arg_phase_q <= 1'b1;
              retries_q   <= '0;
              state_q     <= S_TX_BYTE;
            end else if (!arg_phase_q && cmd_q == CODE_CMD_RESET) begin
              tmr_load_q  <= 1'b1;
              tmr_value_q <= TIMER_W'(BAT_TIMEOUT_CYCLES);
              state_q     <= S_WAIT_BAT;
            end else begin
              cmd_done_q <= 1'b1;
              state_q    <= S_FINISH;
            end
          end else if (rx_valid_i && rx_code_i == CODE_RESEND) begin
            if (retry_ok) begin
              retries_q <= retries_q + RETRY_W'(1);
              state_q   <= S_TX_BYTE;
            end else begin
              cmd_err_q  <= 1'b1;
              err_code_q <= ERR_RESEND_LIMIT;
              state_q    <= S_FAIL;
            end
          end else if (!rx_consumed && timed_out) begin
            cmd_err_q  <= 1'b1;
            err_code_q <= ERR_TIMEOUT;
            state_q    <= S_FAIL;
          end
        end
        S_WAIT_BAT: begin
          if (rx_valid_i && rx_code_i == CODE_BAT_OK) begin
            cmd_done_q <= 1'b1;
            state_q    <= S_FINISH;
          end else if (rx_valid_i && rx_code_i == CODE_BAT_FAIL) begin
            cmd_err_q  <= 1'b1;
            err_code_q <= ERR_BAT_FAIL;
            state_q    <= S_FAIL;
          end else if (timed_out) begin
            cmd_err_q  <= 1'b1;
            err_code_q <= ERR_TIMEOUT;
            state_q    <= S_FAIL;
          end
        end
        S_FINISH, S_FAIL: begin
          req_ready_q <= 1'b1;
          state_q     <= S_IDLE;
        end
        default: begin
          req_ready_q <= 1'b1;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready_o  = req_ready_q;
  assign tx_data_o    = tx_data_q;
  assign tx_start_o   = tx_start_q;
  assign scan_code_o  = scan_code_q;
  assign scan_valid_o = scan_valid_q;
  assign cmd_done_o   = cmd_done_q;
  assign cmd_err_o    = cmd_err_q;
  assign err_code_o   = err_code_q;

endmodule
